mdio_master: RTL and testbench

Clause 22 MDIO/SMI management master for the Ethernet PHY. It serialises single register read/write commands from the control logic onto `phy_mdc` and the tristated `phy_mdio` pin triple (`_i`/`_o`/`_t`). It returns read data through a one-cycle response strobe. It sits inside `top`, runs on `clk_tcxo`, and is the only owner of the PHY management pins.

---
 rtl/mdio_master_pkg.sv | 31 +++
 rtl/mdio_master_if.sv | 31 +++
 rtl/mdio_master_mdc_gen.sv | 51 +++++
 rtl/mdio_master.sv | 204 ++++++++++++++++++++
 tb/tb_mdio_master.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_master_pkg.sv
// Shared types, frame constants and the frame-word builder for the Clause 22 MDIO master.
package mdio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_END  = 3'd5,
        ST_DONE = 3'd6
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam int MDIO_PRE_BITS  = 32;
    localparam int MDIO_HDR_BITS  = 14;
    localparam int MDIO_DATA_BITS = 16;

    // ST..DATA as one 32-bit word; read frames carry ones where the pin is released.
    function automatic logic [31:0] mdio_frame_word(input logic        wr,
                                                    input logic [4:0]  phyad,
                                                    input logic [4:0]  regad,
                                                    input logic [15:0] wdata);
        return {MDIO_ST, (wr ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad,
                (wr ? 2'b10 : 2'b11), (wr ? wdata : 16'hFFFF)};
    endfunction

endpackage

// File: rtl/mdio_master_if.sv
// Command/response bus of the MDIO master; cmd_nopre exists only with MDIO_PREAMBLE_SUPPRESS_EN.
interface mdio_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    logic        cmd_nopre;
`endif
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        input  cmd_nopre,
`endif
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport master (
        output cmd_valid, cmd_write, cmd_phyad, cmd_regad, cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        output cmd_nopre,
`endif
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/mdio_master_mdc_gen.sv
// MDC generator: low for CLK_DIV cycles then high for CLK_DIV cycles while enabled, parked low otherwise.
module mdc_gen #(
    parameter int CLK_DIV = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic mdc,
    output logic fall,
    output logic sample
);
    localparam int PERIOD = 2 * CLK_DIV;
    localparam int CNT_W  = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             last_s;

    // Position within the bit period and the registered MDC level that follows it.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (cnt_q == CNT_W'(PERIOD - 1)) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        mdc_d = (cnt_d >= CNT_W'(CLK_DIV));
    end

    // Counter and MDC registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

    // Last cycle of the high half: MDC falls on the next cycle and the read bit is sampled now.
    assign last_s = en & (cnt_q == CNT_W'(PERIOD - 1));
    assign fall   = last_s;
    assign sample = last_s;
    assign mdc    = mdc_q;

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO master: one register read/write per command, read data via rsp_valid strobe.
// Preamble suppression (cmd_nopre) is compiled in with MDIO_PREAMBLE_SUPPRESS_EN.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 32
) (
    input  logic         clk,
    input  logic         reset,
    mdio_master_if.slave bus,
    output logic         mdc,
    input  logic         mdio_i,
    output logic         mdio_o,
    output logic         mdio_t
);
    mdio_state_e state_q, state_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [31:0] tx_q, tx_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rdata_q, rdata_d;
    logic        write_q, write_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q;
    logic        nopre_s, gen_en_s, fall_s, sample_s, mdc_s;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    assign nopre_s = bus.cmd_nopre;
`else
    assign nopre_s = 1'b0;
`endif

    assign gen_en_s = (state_q == ST_PRE) || (state_q == ST_HDR) || (state_q == ST_TA) ||
                      (state_q == ST_DATA) || (state_q == ST_END);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (gen_en_s),
        .mdc    (mdc_s),
        .fall   (fall_s),
        .sample (sample_s)
    );

    // Frame sequencing; pin values for the next bit are set at the end of the current one.
    always_comb begin
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        mdio_o_d    = mdio_o_q;
        mdio_t_d    = mdio_t_q;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    write_d  = bus.cmd_write;
                    tx_d     = mdio_frame_word(bus.cmd_write, bus.cmd_phyad, bus.cmd_regad, bus.cmd_wdata);
                    mdio_t_d = 1'b1;
                    if (nopre_s) begin
                        state_d  = ST_HDR;
                        bitcnt_d = 5'(MDIO_HDR_BITS - 1);
                        mdio_o_d = tx_d[31];
                    end else begin
                        state_d  = ST_PRE;
                        bitcnt_d = 5'(MDIO_PRE_BITS - 1);
                        mdio_o_d = 1'b1;
                    end
                end else begin
                    mdio_t_d = 1'b0;
                    mdio_o_d = 1'b1;
                end
            end
            ST_PRE: begin
                if (fall_s) begin
                    if (bitcnt_q == 5'd0) begin
                        state_d  = ST_HDR;
                        bitcnt_d = 5'(MDIO_HDR_BITS - 1);
                        mdio_o_d = tx_q[31];
                    end else begin
                        bitcnt_d = bitcnt_q - 5'd1;
                    end
                end else begin
                    state_d = ST_PRE;
                end
            end
            ST_HDR: begin
                if (fall_s) begin
                    tx_d     = {tx_q[30:0], 1'b0};
                    mdio_o_d = tx_q[30];
                    if (bitcnt_q == 5'd0) begin
                        state_d  = ST_TA;
                        bitcnt_d = 5'd1;
                        mdio_t_d = write_q;
                    end else begin
                        bitcnt_d = bitcnt_q - 5'd1;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_TA: begin
                if (fall_s) begin
                    tx_d     = {tx_q[30:0], 1'b0};
                    mdio_o_d = tx_q[30];
                    if (bitcnt_q == 5'd0) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 5'(MDIO_DATA_BITS - 1);
                    end else begin
                        bitcnt_d = bitcnt_q - 5'd1;
                    end
                end else begin
                    state_d = ST_TA;
                end
            end
            ST_DATA: begin
                if (sample_s && !write_q) begin
                    rx_d = {rx_q[14:0], sync2_q};
                end else begin
                    rx_d = rx_q;
                end
                if (fall_s) begin
                    tx_d = {tx_q[30:0], 1'b0};
                    if (bitcnt_q == 5'd0) begin
                        state_d  = ST_END;
                        mdio_t_d = 1'b0;
                        mdio_o_d = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q - 5'd1;
                        mdio_o_d = tx_q[30];
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_END: begin
                if (fall_s) begin
                    state_d     = ST_DONE;
                    rsp_valid_d = 1'b1;
                    rdata_d     = write_q ? rdata_q : rx_q;
                end else begin
                    state_d = ST_END;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mdio_t_d = 1'b0;
                mdio_o_d = 1'b1;
            end
        endcase
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and registered outputs; mdio_i passes through two flops before use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= 5'd0;
            tx_q        <= 32'h0000_0000;
            rx_q        <= 16'h0000;
            rdata_q     <= 16'h0000;
            write_q     <= 1'b0;
            mdio_o_q    <= 1'b1;
            mdio_t_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rdata_q     <= rdata_d;
            write_q     <= write_d;
            mdio_o_q    <= mdio_o_d;
            mdio_t_q    <= mdio_t_d;
            rsp_valid_q <= rsp_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            sync1_q     <= mdio_i;
            sync2_q     <= sync1_q;
        end
    end

    assign mdc           = mdc_s;
    assign mdio_o        = mdio_o_q;
    assign mdio_t        = mdio_t_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master (CLK_DIV=4): a per-cycle frame model plus a pulled-up PHY model.
module tb_mdio_master;
    localparam int D = 4;
    localparam int P = 2 * D;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mdc, mdio_i, mdio_o, mdio_t;
    logic phy_drv = 1'b1;

    mdio_master_if bus();

    mdio_master #(.CLK_DIV(D)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .mdc    (mdc),
        .mdio_i (mdio_i),
        .mdio_o (mdio_o),
        .mdio_t (mdio_t)
    );

    assign mdio_i = mdio_t ? mdio_o : phy_drv;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // PHY configuration chosen by the stimulus
    bit        phy_on = 1'b0;
    bit [15:0] phy_val = 16'h0000;

    // reference model state
    int        m_t = -1;
    bit        m_after_rst = 1'b1;
    bit        m_wr = 1'b0;
    bit        m_phy_on = 1'b0;
    bit [15:0] m_phy_val = 16'h0000;
    bit [15:0] m_rdata = 16'h0000;
    int        m_dstart = 0;
    int        m_acc_cyc = 0;
    bit        m_ft[$];
    bit        m_fo[$];
    int        rsp_cyc[$];
    int        last_lat = 0;
    logic [64:0] dec = 65'd0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_bit(input bit t, input bit o);
        m_ft.push_back(t);
        m_fo.push_back(o);
    endtask

    // Pin-level frame as (drive, value) per bit period, straight from the Clause 22 layout.
    task automatic build_frame(input bit wr, input bit [4:0] pa, input bit [4:0] ra,
                               input bit [15:0] wd, input bit np);
        m_ft.delete();
        m_fo.delete();
        if (!np) for (int i = 0; i < 32; i++) push_bit(1'b1, 1'b1);
        push_bit(1'b1, 1'b0); push_bit(1'b1, 1'b1);
        if (wr) begin push_bit(1'b1, 1'b0); push_bit(1'b1, 1'b1); end
        else    begin push_bit(1'b1, 1'b1); push_bit(1'b1, 1'b0); end
        for (int i = 4; i >= 0; i--) push_bit(1'b1, pa[i]);
        for (int i = 4; i >= 0; i--) push_bit(1'b1, ra[i]);
        if (wr) begin
            push_bit(1'b1, 1'b1); push_bit(1'b1, 1'b0);
            for (int i = 15; i >= 0; i--) push_bit(1'b1, wd[i]);
        end else begin
            for (int i = 0; i < 18; i++) push_bit(1'b0, 1'b1);
        end
        push_bit(1'b0, 1'b1);
    endtask

    // Compare process: predict every output for this cycle, check, then advance the model.
    initial begin
        bit e_ready, e_busy, e_mdc, e_t, e_o, e_rsp, np;
        int len, bi, ki;
        forever begin
            @(negedge clk);
            cyc++;
            len = m_ft.size() * P;
            if (reset) begin
                m_t = -1; m_after_rst = 1'b1; m_rdata = 16'h0000;
                e_ready = 0; e_busy = 0; e_mdc = 0; e_t = 0; e_o = 1; e_rsp = 0;
            end else if (m_t < 0) begin
                e_ready = !m_after_rst; e_busy = 0; e_mdc = 0; e_t = 0; e_o = 1; e_rsp = 0;
            end else if (m_t <= len) begin
                bi = (m_t - 1) / P;
                ki = (m_t - 1) % P;
                e_ready = 0; e_busy = 1; e_mdc = (ki >= D); e_t = m_ft[bi]; e_o = m_fo[bi]; e_rsp = 0;
                if (ki == D) dec = {dec[63:0], (mdio_t ? mdio_o : mdio_i)};
            end else begin
                e_ready = 0; e_busy = 1; e_mdc = 0; e_t = 0; e_o = 1; e_rsp = 1;
                if (!m_wr) m_rdata = m_phy_on ? m_phy_val : 16'hFFFF;
            end
            chk("cmd_ready", bus.cmd_ready, e_ready);
            chk("busy", bus.busy, e_busy);
            chk("mdc", mdc, e_mdc);
            chk("mdio_t", mdio_t, e_t);
            if (e_t) chk("mdio_o", mdio_o, e_o);
            chk("rsp_valid", bus.rsp_valid, e_rsp);
            chk("rsp_rdata", bus.rsp_rdata, m_rdata);
            if (bus.rsp_valid) begin
                rsp_cyc.push_back(cyc);
                last_lat = cyc - m_acc_cyc;
            end
            if (reset) begin
                m_t = -1;
            end else if (m_t < 0) begin
                if (e_ready && bus.cmd_valid) begin
                    np = 1'b0;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
                    np = bus.cmd_nopre;
`endif
                    m_wr = bus.cmd_write;
                    build_frame(bus.cmd_write, bus.cmd_phyad, bus.cmd_regad, bus.cmd_wdata, np);
                    m_phy_on = phy_on;
                    m_phy_val = phy_val;
                    m_dstart = (np ? 0 : 32) + 16;
                    m_t = 1;
                    m_acc_cyc = cyc;
                    dec = 65'd0;
                end
                m_after_rst = 1'b0;
            end else if (m_t <= len) begin
                m_t++;
            end else begin
                m_t = -1;
            end
            // PHY drives each read data bit for the whole bit period
            phy_drv = 1'b1;
            len = m_ft.size() * P;
            if (!reset && m_t >= 1 && m_t <= len && !m_wr && m_phy_on) begin
                bi = (m_t - 1) / P;
                if (bi >= m_dstart && bi < m_dstart + 16) phy_drv = m_phy_val[15 - (bi - m_dstart)];
            end
        end
    end

    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("rsp_timeout", 1'b0, 1'b1);
        #1;
    endtask

    task automatic scramble();
        bus.cmd_write = 1'($urandom);
        bus.cmd_phyad = 5'($urandom);
        bus.cmd_regad = 5'($urandom);
        bus.cmd_wdata = 16'($urandom);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        bus.cmd_nopre = 1'($urandom);
`endif
    endtask

    task automatic send(input bit wr, input bit [4:0] pa, input bit [4:0] ra, input bit [15:0] wd);
        bus.cmd_write = wr;
        bus.cmd_phyad = pa;
        bus.cmd_regad = ra;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        wait_accept();
        bus.cmd_valid = 1'b0;
        scramble();
        wait_rsp();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] exp_w;
        exp_w = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00001, 5'b00000, 2'b10, 16'h1140, 1'b1};
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_phyad = 5'd0;
        bus.cmd_regad = 5'd0;
        bus.cmd_wdata = 16'h0000;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        bus.cmd_nopre = 1'b0;
`endif
        #1 reset = 1'b1;
        #2;
        chk("rst_mdc", mdc, 1'b0);
        chk("rst_mdio_t", mdio_t, 1'b0);
        chk("rst_mdio_o", mdio_o, 1'b1);
        chk("rst_ready", bus.cmd_ready, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rdata", bus.rsp_rdata, 16'h0000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // write 16'h1140 to phy 1 reg 0
        phy_on = 1'b0;
        send(1'b1, 5'd1, 5'd0, 16'h1140);
        chk("wr_latency", last_lat, 521);
        chk("wr_pin_bits", dec, exp_w);
        chk("wr_rdata_kept", bus.rsp_rdata, 16'h0000);

        // read phy 1 reg 2, PHY answers 16'h0022
        phy_on = 1'b1; phy_val = 16'h0022;
        send(1'b0, 5'd1, 5'd2, 16'h0000);
        chk("rd_latency", last_lat, 521);
        chk("rd_rdata", bus.rsp_rdata, 16'h0022);

        // absent PHY: pull-up gives all ones
        phy_on = 1'b0;
        send(1'b0, 5'd3, 5'd1, 16'h0000);
        chk("absent_rdata", bus.rsp_rdata, 16'hFFFF);

        // back-to-back writes with cmd_valid held high
        bus.cmd_write = 1'b1; bus.cmd_phyad = 5'd4; bus.cmd_regad = 5'd9; bus.cmd_wdata = 16'hA5C3;
        bus.cmd_valid = 1'b1;
        wait_accept();
        bus.cmd_wdata = 16'h3C5A; bus.cmd_regad = 5'd10;
        wait_accept();
        bus.cmd_valid = 1'b0;
        wait_rsp();
        chk("b2b_spacing", rsp_cyc[rsp_cyc.size() - 1] - rsp_cyc[rsp_cyc.size() - 2], 522);
        chk("b2b_rdata_kept", bus.rsp_rdata, 16'hFFFF);

        // reset pulse during DATA bit 5 of a read
        phy_on = 1'b1; phy_val = 16'hBEEF;
        bus.cmd_write = 1'b0; bus.cmd_phyad = 5'd2; bus.cmd_regad = 5'd5;
        bus.cmd_valid = 1'b1;
        wait_accept();
        bus.cmd_valid = 1'b0;
        repeat (428) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_mdc", mdc, 1'b0);
        chk("midrst_mdio_t", mdio_t, 1'b0);
        chk("midrst_rdata", bus.rsp_rdata, 16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        phy_on = 1'b1; phy_val = 16'h7E81;
        send(1'b0, 5'd2, 5'd5, 16'h0000);
        chk("after_rst_latency", last_lat, 521);
        chk("after_rst_rdata", bus.rsp_rdata, 16'h7E81);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        // preamble suppressed read
        bus.cmd_nopre = 1'b1;
        phy_on = 1'b1; phy_val = 16'h1234;
        send(1'b0, 5'd1, 5'd2, 16'h0000);
        chk("nopre_latency", last_lat, 265);
        chk("nopre_st_bits", dec[32:31], 2'b01);
        chk("nopre_rdata", bus.rsp_rdata, 16'h1234);
        bus.cmd_nopre = 1'b0;
`endif

        // randomized commands and PHY behaviour
        for (int i = 0; i < 8; i++) begin
            phy_on = ($urandom_range(0, 3) != 0);
            phy_val = 16'($urandom);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
            bus.cmd_nopre = 1'($urandom);
`endif
            send(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
